// File: rtl/rom_fetch_ctrl.sv
// rom_fetch_ctrl: instruction fetch sequencer for a slow parallel ROM.
// It runs a three-state access cycle (IDLE / SETUP / READ) and feeds a
// two-entry in-order prefetch FIFO that is consumed through a valid/ready
// handshake. A redirect pulse flushes the FIFO and restarts fetching at the
// word-aligned target address.
module rom_fetch_ctrl #(
  parameter int unsigned ACCESS_CYCLES = 2,
  parameter logic [31:0] RESET_PC      = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] rom_address,
  output logic        rom_chip_select,
  output logic        rom_output_enable,
  input  logic [63:0] rom_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    READ  = 2'd2
  } state_t;

  // Wait counter reload: the capture happens when the counter reaches zero,
  // so oe stays high for exactly ACCESS_CYCLES cycles.
  localparam logic [3:0] WAIT_LOAD = 4'(ACCESS_CYCLES - 1);
  localparam logic [1:0] DEPTH     = 2'd2;

  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [3:0]  wait_q, wait_d;
  logic        cs_q, cs_d;
  logic        oe_q, oe_d;
  logic [1:0]  count_q, count_d;
  logic [31:0] slot_instr_q [2];
  logic [31:0] slot_instr_d [2];
  logic [31:0] slot_pc_q    [2];
  logic [31:0] slot_pc_d    [2];

  logic        pop;
  logic        capture;
  logic [1:0]  after_pop;
  logic [1:0]  after_push;

  // Upper half of the ROM bus carries nothing we need.
  logic        unused_rom_hi;
  assign unused_rom_hi = ^rom_data[63:32];

  // All outputs come straight from flops; slot 0 is always the FIFO head.
  assign rom_address       = fetch_pc_q;
  assign rom_chip_select   = cs_q;
  assign rom_output_enable = oe_q;
  assign instr_valid       = (count_q != 2'd0);
  assign instr             = slot_instr_q[0];
  assign instr_pc          = slot_pc_q[0];

  // Next-state logic: access sequencing, FIFO push/pop and redirect flush.
  always_comb begin
    pop        = instr_valid && instr_ready;
    capture    = (state_q == READ) && (wait_q == 4'd0);
    after_pop  = count_q - {1'b0, pop};
    after_push = after_pop + 2'd1;

    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    wait_d       = wait_q;
    cs_d         = cs_q;
    oe_d         = oe_q;
    count_d      = count_q;
    slot_instr_d = slot_instr_q;
    slot_pc_d    = slot_pc_q;

    if (redirect_valid) begin
      // Redirect wins over everything: any in-flight word and any pop are
      // discarded, and the ROM is released on the next cycle.
      state_d    = IDLE;
      cs_d       = 1'b0;
      oe_d       = 1'b0;
      count_d    = 2'd0;
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
    end else begin
      count_d = after_pop;
      if (pop) begin
        slot_instr_d[0] = slot_instr_q[1];
        slot_pc_d[0]    = slot_pc_q[1];
      end

      case (state_q)
        IDLE: begin
          // Only start an access when a slot is free, so a capture can
          // never overflow the FIFO.
          if (count_q < DEPTH) begin
            state_d = SETUP;
            cs_d    = 1'b1;
            oe_d    = 1'b0;
          end
        end
        SETUP: begin
          state_d = READ;
          oe_d    = 1'b1;
          wait_d  = WAIT_LOAD;
        end
        READ: begin
          if (!capture) begin
            wait_d = wait_q - 4'd1;
          end else begin
            // Tail position accounts for a pop on the same edge.
            slot_instr_d[after_pop[0]] = rom_data[31:0];
            slot_pc_d[after_pop[0]]    = fetch_pc_q;
            count_d                    = after_push;
            fetch_pc_d                 = fetch_pc_q + 32'd4;
            if (after_push < DEPTH) begin
              state_d = SETUP;
              cs_d    = 1'b1;
              oe_d    = 1'b0;
            end else begin
              state_d = IDLE;
              cs_d    = 1'b0;
              oe_d    = 1'b0;
            end
          end
        end
        default: begin
          state_d = IDLE;
          cs_d    = 1'b0;
          oe_d    = 1'b0;
        end
      endcase
    end
  end

  // State register; reset aborts any access and empties the FIFO at once.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      wait_q     <= 4'd0;
      cs_q       <= 1'b0;
      oe_q       <= 1'b0;
      count_q    <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        slot_instr_q[i] <= 32'd0;
        slot_pc_q[i]    <= 32'd0;
      end
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      wait_q       <= wait_d;
      cs_q         <= cs_d;
      oe_q         <= oe_d;
      count_q      <= count_d;
      slot_instr_q <= slot_instr_d;
      slot_pc_q    <= slot_pc_d;
    end
  end

endmodule
